// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state and mode encodings for the programmable pulse counter
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/prog_pulse_counter.sv
// rtl/prog_pulse_counter.sv - programmable periodic/one-shot tick generator with busy/done status
module prog_pulse_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_TC = WIDTH'(9)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] terminal_count,
    output logic [WIDTH-1:0] count,
    output logic             count_pulse,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_tc_q, w_tc_nxt;
    logic             r_mode_q, w_mode_nxt;
    logic             r_pulse, w_pulse_nxt;
    logic             r_done, w_done_nxt;
    logic             w_hit;

    assign w_hit = (r_count == r_tc_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_tc_q   <= RESET_TC;
            r_mode_q <= MODE_PERIODIC;
            r_pulse  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_tc_q   <= w_tc_nxt;
            r_mode_q <= w_mode_nxt;
            r_pulse  <= w_pulse_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // clear beats start; start beats normal counting, so a start on the hit edge suppresses the pulse
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = r_tc_q;
        w_mode_nxt  = r_mode_q;
        w_pulse_nxt = 1'b0;
        w_done_nxt  = r_done;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
        end else if (start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_tc_nxt    = terminal_count;
            w_mode_nxt  = mode;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (enable) begin
                        if (w_hit) begin
                            w_count_nxt = '0;
                            w_pulse_nxt = 1'b1;
                            if (r_mode_q == MODE_ONESHOT) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                // new terminal count applies from the next period only
                                w_tc_nxt = terminal_count;
                            end
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    w_count_nxt = '0;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign count       = r_count;
    assign count_pulse = r_pulse;
    assign busy        = (r_state == ST_RUN);
    assign done        = r_done;

endmodule

// File: tb/tb_prog_pulse_counter.sv
// tb/tb_prog_pulse_counter.sv - vector-table and sequence checks for prog_pulse_counter
module tb_prog_pulse_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] terminal_count = 8'd0;
    logic [7:0] count;
    logic       count_pulse;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst_n;
        logic       enable;
        logic       start;
        logic       clear;
        logic       mode;
        logic [7:0] tc;
        logic [7:0] exp_count;
        logic       exp_pulse;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    prog_pulse_counter #(.WIDTH(8), .RESET_TC(8'd9)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .start          (start),
        .clear          (clear),
        .mode           (mode),
        .terminal_count (terminal_count),
        .count          (count),
        .count_pulse    (count_pulse),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic s, input logic c, input logic m,
                       input logic [7:0] tc, input logic [7:0] ec, input logic ep,
                       input logic eb, input logic ed);
        vec_t v;
        v.rst_n = r; v.enable = e; v.start = s; v.clear = c; v.mode = m; v.tc = tc;
        v.exp_count = ec; v.exp_pulse = ep; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input int idx, input logic [31:0] got,
                          input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    initial begin
        int cyc;
        int first_pulse;
        int second_pulse;

        // reset, then idle ignores enable
        add(0,0,0,0,0,8'd0,   8'd0,0,0,0);
        add(0,0,0,0,0,8'd0,   8'd0,0,0,0);
        add(1,1,0,0,0,8'd0,   8'd0,0,0,0);
        add(1,1,0,0,0,8'd0,   8'd0,0,0,0);

        // periodic tc=4: 4 pulses in 20 cycles, spaced 5
        add(1,1,1,0,0,8'd4,   8'd0,0,1,0);
        for (int i = 1; i <= 20; i++)
            add(1,1,0,0,0,8'd4, 8'(i % 5), (i % 5) == 0, 1, 0);

        // enable gating tc=3: hold at 2 for 3 cycles
        add(1,1,1,0,0,8'd3,   8'd0,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd2,0,1,0);
        for (int i = 0; i < 3; i++)
            add(1,0,0,0,0,8'd3, 8'd2,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd3,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd0,1,1,0);
        add(1,1,0,0,0,8'd3,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd2,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd3,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd0,1,1,0);

        // one-shot tc=6: single pulse 7 cycles after start, then DONE ignores enable
        add(1,1,1,0,1,8'd6,   8'd0,0,1,0);
        for (int i = 1; i <= 6; i++)
            add(1,1,0,0,0,8'd6, 8'(i),0,1,0);
        add(1,1,0,0,0,8'd6,   8'd0,1,0,1);
        for (int i = 0; i < 20; i++)
            add(1,1,0,0,0,8'd6, 8'd0,0,0,1);
        add(1,1,1,0,0,8'd2,   8'd0,0,1,0);

        // tc=0 periodic: pulse every enabled cycle
        add(1,1,1,0,0,8'd0,   8'd0,0,1,0);
        for (int i = 0; i < 4; i++)
            add(1,1,0,0,0,8'd0, 8'd0,1,1,0);

        // tc=255 wraps cleanly
        add(1,1,1,0,0,8'd255, 8'd0,0,1,0);
        for (int i = 1; i <= 255; i++)
            add(1,1,0,0,0,8'd255, 8'(i),0,1,0);
        add(1,1,0,0,0,8'd255, 8'd0,1,1,0);

        // tc 4 -> 2 mid-period: current period 5, next 3
        add(1,1,1,0,0,8'd4,   8'd0,0,1,0);
        add(1,1,0,0,0,8'd4,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd4,   8'd2,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd3,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd4,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd0,1,1,0);
        add(1,1,0,0,0,8'd2,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd2,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd0,1,1,0);

        // start coincident with hit edge: no pulse, restart
        add(1,1,0,0,0,8'd2,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd2,0,1,0);
        add(1,1,1,0,0,8'd2,   8'd0,0,1,0);
        add(1,1,0,0,0,8'd2,   8'd1,0,1,0);

        // clear during RUN, and clear beats start
        add(1,1,0,1,0,8'd2,   8'd0,0,0,0);
        add(1,1,0,0,0,8'd2,   8'd0,0,0,0);
        add(1,1,1,1,0,8'd2,   8'd0,0,0,0);

        // clear after one-shot completion drops done
        add(1,1,1,0,1,8'd0,   8'd0,0,1,0);
        add(1,1,0,0,0,8'd0,   8'd0,1,0,1);
        add(1,1,0,1,0,8'd0,   8'd0,0,0,0);

        // reset on the hit edge: no pulse, all outputs cleared
        add(1,1,1,0,0,8'd3,   8'd0,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd1,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd2,0,1,0);
        add(1,1,0,0,0,8'd3,   8'd3,0,1,0);
        add(0,1,0,0,0,8'd3,   8'd0,0,0,0);
        add(1,1,0,0,0,8'd3,   8'd0,0,0,0);

        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            enable = vecs[i].enable;
            start = vecs[i].start;
            clear = vecs[i].clear;
            mode = vecs[i].mode;
            terminal_count = vecs[i].tc;
            tick();
            check1("count", i, 32'(count), 32'(vecs[i].exp_count));
            check1("count_pulse", i, 32'(count_pulse), 32'(vecs[i].exp_pulse));
            check1("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
            check1("done", i, 32'(done), 32'(vecs[i].exp_done));
        end

        // periodic tc=1: measure pulse spacing with bounded waits
        rst_n = 1; clear = 0; mode = 0; terminal_count = 8'd1; enable = 1; start = 1;
        tick();
        start = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (cyc = 1; cyc <= 12 && second_pulse < 0; cyc++) begin
            tick();
            if (count_pulse) begin
                if (first_pulse < 0) first_pulse = cyc;
                else second_pulse = cyc;
            end
        end
        check1("first_pulse_latency", 0, 32'(first_pulse), 32'd2);
        check1("pulse_interval", 0, 32'(second_pulse - first_pulse), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_pulse_counter.md
Name: prog_pulse_counter

Overview:
Parametrised successor to the fixed-period enable-driven pulse counter. It generates a single-cycle count_pulse every (terminal_count+1) enabled cycles. It adds a runtime-programmable terminal count, periodic and one-shot modes, explicit start/clear control, and busy/done status. It sits beside timing/strobe logic and feeds tick enables to downstream blocks.

Parameters:
WIDTH, 8, counter and terminal-count width in bits (2..32)
RESET_TC, 8'd9, terminal count loaded into tc_q at reset; value is WIDTH bits wide

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
enable  input  1  count-advance qualifier; low freezes count
start  input  1  single-cycle request: latch terminal_count and mode, restart count from 0
clear  input  1  synchronous abort to IDLE
mode  input  1  0 = periodic, 1 = one-shot; sampled only on start
terminal_count  input  WIDTH  last count value before wrap; sampled on start and on periodic wrap
count  output  WIDTH  current count value (registered)
count_pulse  output  1  one-cycle pulse on terminal-count hit (registered)
busy  output  1  high in RUN
done  output  1  sticky; one-shot completed

Behaviour:
- All outputs are registered. Priority per edge: rst_n low > clear > start > normal operation.
- Reset (rst_n=0 at posedge): state=IDLE, count=0, count_pulse=0, done=0, tc_q=RESET_TC, mode_q=0. busy=0 follows from IDLE.
- FSM states: IDLE, RUN, DONE (2-bit encoding). busy = (state==RUN).
- clear=1: state=IDLE, count=0, count_pulse=0, done=0. tc_q and mode_q hold.
- start=1 in any state: tc_q<=terminal_count, mode_q<=mode, count<=0, count_pulse<=0, done<=0, state<=RUN. A start in RUN restarts; no pulse is emitted on that edge even if count==tc_q.
- RUN, enable=0: count holds; count_pulse<=0.
- RUN, enable=1, count!=tc_q: count<=count+1; count_pulse<=0.
- RUN, enable=1, count==tc_q:
  - count<=0 and count_pulse<=1.
  - Periodic (mode_q=0): tc_q<=terminal_count, so a new tc takes effect from the next period; state stays RUN.
  - One-shot (mode_q=1): state<=DONE, done<=1.
- Pulse timing: count_pulse is high for exactly the one cycle in which count reads 0 after the wrap. Period is (tc_q+1) enabled cycles. tc_q=0 with enable held high gives count_pulse continuously high and count stuck at 0.
- DONE: count holds 0, count_pulse=0, done=1 until start or clear. enable is ignored.
- IDLE: count holds 0, outputs 0. enable is ignored.
- terminal_count changes mid-period have no effect until the next start or periodic wrap. count can never exceed tc_q, so no overflow path exists; a max-value tc (all ones) wraps cleanly to 0.
- Reset asserted mid-RUN aborts immediately on that edge; no pulse is emitted.
- Latency: start at edge N gives count=0 after N. With enable held high, the first pulse is visible after edge N+tc+1.

Decomposition:
- Shared package counter_pkg holds:
  - state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1
- No sub-module. A single always block for state/count/tc_q/mode_q plus the comparator is the natural size (~150 lines).

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> count=0, count_pulse=0, busy=0, done=0, tc_q=9; enable=1 without start leaves count at 0.
- Periodic: WIDTH=8, start with tc=4, mode=0, enable held high for 20 cycles -> count sequence 0,1,2,3,4,0,..., 4 pulses spaced exactly 5 cycles, busy=1, done=0.
- Enable gating: periodic tc=3, drop enable for 3 cycles when count=2 -> count holds 2 with no pulse; the pulse arrives 3 cycles late and period resumes at 4.
- One-shot: start tc=6, mode=1 -> exactly one pulse 7 cycles after start, then state DONE, done=1, busy=0; a further 20 enabled cycles produce no pulse; a new start clears done.
- Boundaries:
  - tc=0 periodic gives count_pulse high every enabled cycle.
  - tc=255 wraps 255->0 with a pulse.
  - Changing terminal_count from 4 to 2 mid-period gives the current period at 5 cycles and the next at 3.
- Priority/abort:
  - start coincident with the count==tc edge gives count=0 and no pulse.
  - clear during RUN gives IDLE with count=0.
  - rst_n=0 mid-RUN clears all outputs on that edge.
